// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, ALUOp encodings and the decoded control bundle shared by the decode stage
package mips_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    typedef struct packed {
        logic       regdst;
        logic       alusrc;
        logic       branch;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
        logic [1:0] aluop;
    } ctrl_t;
endpackage

// File: rtl/regfile_p.sv
// regfile_p: register file, two bypassed read ports, one write port, r0 hardwired to zero
module regfile_p #(
    parameter int DATA_W = 32,
    parameter int NREGS = 32,
    localparam int AW = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic [AW-1:0]           waddr,
    input  logic [DATA_W-1:0]       wdata,
    input  logic [AW-1:0]           raddrA,
    input  logic [AW-1:0]           raddrB,
    output logic [DATA_W-1:0]       rdataA,
    output logic [DATA_W-1:0]       rdataB,
    output logic [NREGS*DATA_W-1:0] regsFlat
);
    logic [NREGS-1:0][DATA_W-1:0] regs;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) regs <= '0;
        else if (we && waddr != '0) regs[waddr] <= wdata;
    end
    // write-back data bypasses the array so a same-cycle write is seen by ID
    assign rdataA = (raddrA == '0) ? '0 : (we && waddr == raddrA) ? wdata : regs[raddrA];
    assign rdataB = (raddrB == '0) ? '0 : (we && waddr == raddrB) ? wdata : regs[raddrB];
    assign regsFlat = regs;
endmodule

// File: rtl/decode_stage_p.sv
// decode_stage_p: MIPS ID stage with register file, control decode, load-use stall and ID/EX register
module decode_stage_p
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W = 10,
    parameter int NREGS = 32,
    localparam int AW = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             instr_i,
    input  logic [PC_W-1:0]         pc_i,
    input  logic                    valid_i,
    input  logic                    flush_i,
    input  logic                    wb_we_i,
    input  logic [AW-1:0]           wb_addr_i,
    input  logic [DATA_W-1:0]       wb_data_i,
    output logic                    stall_o,
    output logic                    jump_o,
    output logic                    regdst_o,
    output logic                    alusrc_o,
    output logic                    branch_o,
    output logic                    memread_o,
    output logic                    memwrite_o,
    output logic                    memtoreg_o,
    output logic                    regwrite_o,
    output logic [1:0]              aluop_o,
    output logic [DATA_W-1:0]       rega_o,
    output logic [DATA_W-1:0]       regb_o,
    output logic [DATA_W-1:0]       imm_o,
    output logic [PC_W-1:0]         pc_o,
    output logic [AW-1:0]           rs_o,
    output logic [AW-1:0]           rt_o,
    output logic [AW-1:0]           rd_o,
    output logic                    valid_o,
    output logic [NREGS*DATA_W-1:0] regs_o
);
    logic [5:0]        opcode;
    logic [AW-1:0]     rs, rt, rd;
    logic [DATA_W-1:0] rdA, rdB, immExt;
    ctrl_t             ctrl, ctrlQ;
    logic              usesRt, load;
    assign opcode = instr_i[31:26];
    assign rs = instr_i[21 +: AW];
    assign rt = instr_i[16 +: AW];
    assign rd = instr_i[11 +: AW];
    assign immExt = DATA_W'($signed(instr_i[15:0]));
    regfile_p #(.DATA_W(DATA_W), .NREGS(NREGS)) uRegs (
        .clk(clk),
        .reset(reset),
        .we(wb_we_i),
        .waddr(wb_addr_i),
        .wdata(wb_data_i),
        .raddrA(rs),
        .raddrB(rt),
        .rdataA(rdA),
        .rdataB(rdB),
        .regsFlat(regs_o)
    );
    always_comb begin
        ctrl = '0;
        usesRt = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.regdst = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.aluop = ALU_RTYPE;
                usesRt = 1'b1;
            end
            OP_LW: begin
                ctrl.alusrc = 1'b1;
                ctrl.memread = 1'b1;
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.aluop = ALU_ADD;
            end
            OP_SW: begin
                ctrl.alusrc = 1'b1;
                ctrl.memwrite = 1'b1;
                ctrl.aluop = ALU_ADD;
                usesRt = 1'b1;
            end
            OP_BEQ: begin
                ctrl.branch = 1'b1;
                ctrl.aluop = ALU_SUB;
                usesRt = 1'b1;
            end
            OP_ADDI: begin
                ctrl.alusrc = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.aluop = ALU_ADD;
            end
            default: ;
        endcase
    end
    // a load in EX whose destination feeds this instruction holds fetch for one cycle
    assign stall_o = valid_i && valid_o && memread_o && rt_o != '0 &&
                     (rt_o == rs || (usesRt && rt_o == rt)) && !flush_i;
    assign jump_o = valid_i && opcode == OP_J;
    assign load = valid_i && !flush_i && !stall_o;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrlQ <= '0;
            rega_o <= '0;
            regb_o <= '0;
            imm_o <= '0;
            pc_o <= '0;
            rs_o <= '0;
            rt_o <= '0;
            rd_o <= '0;
            valid_o <= 1'b0;
        end else begin
            ctrlQ <= load ? ctrl : '0;
            rega_o <= load ? rdA : '0;
            regb_o <= load ? rdB : '0;
            imm_o <= load ? immExt : '0;
            pc_o <= load ? pc_i : '0;
            rs_o <= load ? rs : '0;
            rt_o <= load ? rt : '0;
            rd_o <= load ? rd : '0;
            valid_o <= load;
        end
    end
    assign regdst_o = ctrlQ.regdst;
    assign alusrc_o = ctrlQ.alusrc;
    assign branch_o = ctrlQ.branch;
    assign memread_o = ctrlQ.memread;
    assign memwrite_o = ctrlQ.memwrite;
    assign memtoreg_o = ctrlQ.memtoreg;
    assign regwrite_o = ctrlQ.regwrite;
    assign aluop_o = ctrlQ.aluop;
endmodule

// File: tb/tb_decode_stage_p.sv
// tb_decode_stage_p: directed vectors against hand-computed decode, bypass and hazard results
module tb_decode_stage_p;
    localparam int DATA_W = 32;
    localparam int PC_W = 10;
    localparam int NREGS = 32;
    localparam int AW = 5;
    localparam logic [8:0] C_R    = 9'b1_0_0_0_0_0_1_10;
    localparam logic [8:0] C_LW   = 9'b0_1_0_1_0_1_1_00;
    localparam logic [8:0] C_SW   = 9'b0_1_0_0_1_0_0_00;
    localparam logic [8:0] C_BEQ  = 9'b0_0_1_0_0_0_0_01;
    localparam logic [8:0] C_ADDI = 9'b0_1_0_0_0_0_1_00;
    logic clk = 1'b0;
    logic reset;
    logic [31:0] instr_i;
    logic [PC_W-1:0] pc_i;
    logic valid_i, flush_i, wb_we_i;
    logic [AW-1:0] wb_addr_i;
    logic [DATA_W-1:0] wb_data_i;
    logic stall_o, jump_o, regdst_o, alusrc_o, branch_o, memread_o, memwrite_o, memtoreg_o, regwrite_o;
    logic [1:0] aluop_o;
    logic [DATA_W-1:0] rega_o, regb_o, imm_o;
    logic [PC_W-1:0] pc_o;
    logic [AW-1:0] rs_o, rt_o, rd_o;
    logic valid_o;
    logic [NREGS*DATA_W-1:0] regs_o;
    logic [8:0] ctl;
    int total = 0;
    int bad = 0;
    decode_stage_p #(.DATA_W(DATA_W), .PC_W(PC_W), .NREGS(NREGS)) dut (
        .clk(clk), .reset(reset), .instr_i(instr_i), .pc_i(pc_i), .valid_i(valid_i),
        .flush_i(flush_i), .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
        .stall_o(stall_o), .jump_o(jump_o), .regdst_o(regdst_o), .alusrc_o(alusrc_o),
        .branch_o(branch_o), .memread_o(memread_o), .memwrite_o(memwrite_o),
        .memtoreg_o(memtoreg_o), .regwrite_o(regwrite_o), .aluop_o(aluop_o),
        .rega_o(rega_o), .regb_o(regb_o), .imm_o(imm_o), .pc_o(pc_o), .rs_o(rs_o),
        .rt_o(rt_o), .rd_o(rd_o), .valid_o(valid_o), .regs_o(regs_o)
    );
    assign ctl = {regdst_o, alusrc_o, branch_o, memread_o, memwrite_o, memtoreg_o, regwrite_o, aluop_o};
    always #5 clk = ~clk;
    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic drive(input logic [31:0] ins, input logic v, input logic f);
        instr_i = ins;
        valid_i = v;
        flush_i = f;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    initial begin
        reset = 1'b0;
        pc_i = '0;
        wb_we_i = 1'b0;
        wb_addr_i = '0;
        wb_data_i = '0;
        drive(32'h08000010, 1'b1, 1'b0);
        #1;
        checkVal("rst_jump", jump_o, 1);
        checkVal("rst_stall", stall_o, 0);
        repeat (2) @(posedge clk);
        #1;
        checkVal("rst_valid", valid_o, 0);
        checkVal("rst_ctl", ctl, 0);
        checkVal("rst_rega", rega_o, 0);
        checkVal("rst_imm", imm_o, 0);
        checkVal("rst_pc", pc_o, 0);
        checkVal("rst_regs", |regs_o, 0);
        reset = 1'b1;
        valid_i = 1'b0;
        wb_we_i = 1'b1; wb_addr_i = 5; wb_data_i = 32'hAA;
        tick();
        wb_we_i = 1'b0;
        checkVal("wb_r5", regs_o[5*DATA_W +: DATA_W], 32'hAA);
        checkVal("novalid_bubble", valid_o, 0);
        drive(32'h00A51820, 1'b1, 1'b0); pc_i = 10'h12;
        tick();
        checkVal("add_rega", rega_o, 32'hAA);
        checkVal("add_regb", regb_o, 32'hAA);
        checkVal("add_ctl", ctl, C_R);
        checkVal("add_rd", rd_o, 3);
        checkVal("add_rs", rs_o, 5);
        checkVal("add_pc", pc_o, 10'h12);
        checkVal("add_valid", valid_o, 1);
        wb_we_i = 1'b1; wb_addr_i = 7; wb_data_i = 32'h1234;
        drive(32'h00E04020, 1'b1, 1'b0);
        tick();
        checkVal("bypass_rega", rega_o, 32'h1234);
        checkVal("bypass_regb_r0", regb_o, 0);
        checkVal("bypass_rd", rd_o, 8);
        wb_addr_i = 0; wb_data_i = 32'hFFFF;
        drive(32'h00074820, 1'b1, 1'b0);
        tick();
        wb_we_i = 1'b0;
        checkVal("r0_read", rega_o, 0);
        checkVal("r7_read", regb_o, 32'h1234);
        checkVal("r0_store", regs_o[DATA_W-1:0], 0);
        drive(32'h8C220004, 1'b1, 1'b0);
        tick();
        checkVal("lw_ctl", ctl, C_LW);
        checkVal("lw_rt", rt_o, 2);
        checkVal("lw_imm", imm_o, 4);
        drive(32'h00432020, 1'b1, 1'b0);
        #1;
        checkVal("lu_stall", stall_o, 1);
        wb_we_i = 1'b1; wb_addr_i = 2; wb_data_i = 32'h55;
        tick();
        wb_we_i = 1'b0;
        checkVal("lu_bubble_valid", valid_o, 0);
        checkVal("lu_bubble_ctl", ctl, 0);
        checkVal("lu_stall_drop", stall_o, 0);
        tick();
        checkVal("lu_reissue_valid", valid_o, 1);
        checkVal("lu_reissue_rega", rega_o, 32'h55);
        checkVal("lu_reissue_rd", rd_o, 4);
        checkVal("lu_reissue_ctl", ctl, C_R);
        drive(32'h8C220004, 1'b1, 1'b0);
        tick();
        drive(32'h20620001, 1'b1, 1'b0);
        #1;
        checkVal("addi_no_stall", stall_o, 0);
        tick();
        checkVal("addi_ctl", ctl, C_ADDI);
        checkVal("addi_imm", imm_o, 1);
        checkVal("addi_valid", valid_o, 1);
        drive(32'h8C220004, 1'b1, 1'b0);
        tick();
        drive(32'h00432020, 1'b1, 1'b1);
        #1;
        checkVal("flush_hazard_stall", stall_o, 0);
        tick();
        checkVal("flush_valid", valid_o, 0);
        checkVal("flush_ctl", ctl, 0);
        drive(32'h10220003, 1'b1, 1'b1);
        tick();
        checkVal("beq_flush_branch", branch_o, 0);
        checkVal("beq_flush_valid", valid_o, 0);
        drive(32'h10220003, 1'b1, 1'b0);
        tick();
        checkVal("beq_ctl", ctl, C_BEQ);
        checkVal("beq_regb", regb_o, 32'h55);
        checkVal("beq_valid", valid_o, 1);
        drive(32'h2001FFFF, 1'b1, 1'b0);
        tick();
        checkVal("neg_imm", imm_o, 32'hFFFF_FFFF);
        checkVal("neg_alusrc", alusrc_o, 1);
        drive(32'hAC050008, 1'b1, 1'b0);
        tick();
        checkVal("sw_ctl", ctl, C_SW);
        checkVal("sw_regb", regb_o, 32'hAA);
        checkVal("sw_imm", imm_o, 8);
        drive(32'h08000010, 1'b1, 1'b0);
        #1;
        checkVal("j_jump", jump_o, 1);
        tick();
        checkVal("j_ctl", ctl, 0);
        checkVal("j_valid", valid_o, 1);
        drive(32'h08000010, 1'b0, 1'b0);
        #1;
        checkVal("j_gated", jump_o, 0);
        drive(32'hFC000000, 1'b1, 1'b0);
        tick();
        checkVal("unk_ctl", ctl, 0);
        checkVal("unk_valid", valid_o, 1);
        drive(32'h8C220004, 1'b1, 1'b0);
        tick();
        drive(32'h00432020, 1'b1, 1'b0);
        #1;
        checkVal("rst_mid_stall_pre", stall_o, 1);
        #2 reset = 1'b0;
        #1;
        checkVal("rst_mid_stall", stall_o, 0);
        checkVal("rst_mid_valid", valid_o, 0);
        checkVal("rst_mid_regs", regs_o[5*DATA_W +: DATA_W], 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
